pwm_timer: RTL and testbench
============================

# pwm_timer

Single-channel prescaled PWM timer that consumes the flat configuration bus produced by the SPI register wrapper and returns a flat status bus to it. Sits directly downstream of the wrapper's `config_regs` output and directly upstream of its `status_regs` input. Adds free-running and one-shot modes, a wrap pulse and a saturating wrap counter; all control comes over SPI register writes.

## Interface
- `NUM_CFG`, 8, number of config bytes on `config_regs` (only bytes 0–3 used; must be ≥4)
- `NUM_STATUS`, 8, number of status bytes on `status_regs` (bytes 0–3 driven, rest tied 0; must be ≥4)
- `REG_WIDTH`, 8, register width in bits (block is specified for 8 only)

- `clk` input 1 system clock; single clock domain
- `rstb` input 1 reset, asynchronous, active-low
- `ena` input 1 global enable; 0 freezes every register in the block
- `config_regs` input NUM_CFG*REG_WIDTH packed config bytes, byte n at bits [8n+7:8n]
- `status_regs` output NUM_STATUS*REG_WIDTH packed status bytes, same packing
- `pwm_out` output 1 registered PWM output
- `wrap_pulse` output 1 one-clk pulse on each counter wrap

## Operation
- Config map: byte0 CTRL {bit0 RUN, bit1 ONESHOT, bit2 INVERT, bits7:3 ignored}; byte1 PRESCALE; byte2 PERIOD; byte3 DUTY.
- Status map: byte0 = count; byte1 = wrap_cnt; byte2 = {5'b0, done, running, pwm_out}; byte3 = 8'hA5 (ID); bytes ≥4 = 0.
- States: IDLE, RUN, DONE (2-bit encoding, reset IDLE).
- IDLE: presc=0, count=0. RUN=1 → RUN state; on this transition wrap_cnt←0 and period/duty shadows loaded.
- RUN: presc counts 0..PRESCALE; tick when presc==PRESCALE, presc←0. On tick: if count==period_eff then count←0, wrap_pulse=1, wrap_cnt+1 (saturates at 255), shadows reload; else count+1.
- RUN with ONESHOT=1 at a wrap → DONE (count←0, wrap still pulsed and counted).
- RUN=0 in RUN or DONE → IDLE next enabled clock; wrap_cnt holds its value.
- pwm_out ← INVERT ^ (state==RUN && count < duty_eff). IDLE/DONE drive INVERT.
- running = (state==RUN); done = (state==DONE).
- PRESCALE is always used live; only PERIOD/DUTY are shadowed (see Configuration).

## Timing
- Reset values: state IDLE, presc 0, count 0, wrap_cnt 0, shadows 0, pwm_out 0, wrap_pulse 0; status_regs = byte3 8'hA5, all else 0.
- All outputs registered; status_regs reflects registers of the same cycle (no extra latency).
- First tick occurs PRESCALE+1 enabled clocks after RUN state entry.
- pwm_out lags count by one clk; wrap_pulse asserts in the clk where count goes to 0.
- ena=0: no state, counter or output changes; a pending wrap_pulse is held for that cycle then cleared on the next enabled clock.
- Boundaries: PERIOD=0 → wrap every tick; DUTY=0 → pwm_out=INVERT always; DUTY>PERIOD → pwm_out=~INVERT throughout RUN; PRESCALE changed mid-count below current presc → presc wraps at 255 before matching (no special handling).
- RUN cleared in the same clk as a wrap: wrap counted and pulsed, state → IDLE.
- Reset asserted mid-run: immediate return to reset values.

## Configuration
- `PWM_TIMER_SHADOW_EN` defined: period_eff/duty_eff are shadow registers loaded on IDLE→RUN and on every wrap; mid-period writes take effect at next wrap.
- Undefined: period_eff/duty_eff are config bytes 2/3 used live; writes take effect on the next tick compare; no shadow flops.

## Test plan
- Reset: rstb low → status byte3=8'hA5, all other status bytes 0, pwm_out=0, wrap_pulse=0.
- Free run: PRESCALE=0, PERIOD=3, DUTY=2, RUN=1 → pwm_out high 2 of every 4 clks, wrap_pulse every 4 clks, wrap_cnt increments.
- Prescale: PRESCALE=4, PERIOD=1 → first tick 5 clks after RUN, wrap_pulse every 10 clks.
- One-shot: ONESHOT=1, PERIOD=5 → single wrap_pulse, status byte2=8'h04 (done), count=0; RUN=0 → byte2=0.
- Saturation/invert: PERIOD=0, PRESCALE=0, INVERT=1, DUTY=0 for 300 clks → wrap_cnt=255, pwm_out=1 constant.
- Shadow (macro on): change PERIOD 7→2 at count=3 → current period completes at 7, next period wraps at 2; macro off → wraps at 2 immediately unless count>2, which runs to 255 and wraps.

Source files
------------

// File: rtl/pwm_timer.sv
// Single-channel prescaled PWM timer driven by the SPI config bus, reporting on the status bus.
// Define PWM_TIMER_SHADOW_EN to double-buffer PERIOD/DUTY so they only change at a wrap.
module pwm_timer #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            pwm_out,
  output logic                            wrap_pulse
);
  localparam int W = REG_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state;
  logic [W-1:0]   presc, count, wrap_cnt;
  logic [W-1:0]   ctrl, prescale, period_cfg, duty_cfg;
  logic [W-1:0]   period_eff, duty_eff;
  logic           run, oneshot, invert, tick, wrap_now, load_sh;
  logic           unused_cfg;

  assign ctrl       = config_regs[0   +: W];
  assign prescale   = config_regs[W   +: W];
  assign period_cfg = config_regs[2*W +: W];
  assign duty_cfg   = config_regs[3*W +: W];
  assign run        = ctrl[0];
  assign oneshot    = ctrl[1];
  assign invert     = ctrl[2];
  assign unused_cfg = ^config_regs;

  assign tick     = (presc == prescale);
  assign wrap_now = (state == RUN) && tick && (count == period_eff);
  assign load_sh  = ena && (((state == IDLE) && run) || wrap_now);

`ifdef PWM_TIMER_SHADOW_EN
  logic [W-1:0] period_sh, duty_sh;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      period_sh <= '0;
      duty_sh   <= '0;
    end else if (load_sh) begin
      period_sh <= period_cfg;
      duty_sh   <= duty_cfg;
    end
  end

  assign period_eff = period_sh;
  assign duty_eff   = duty_sh;
`else
  logic unused_load;
  assign unused_load = load_sh;
  assign period_eff  = period_cfg;
  assign duty_eff    = duty_cfg;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      presc      <= '0;
      count      <= '0;
      wrap_cnt   <= '0;
      pwm_out    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else if (ena) begin
      wrap_pulse <= 1'b0;
      pwm_out    <= invert ^ ((state == RUN) && (count < duty_eff));
      case (state)
        IDLE: begin
          presc <= '0;
          count <= '0;
          if (run) begin
            state    <= RUN;
            wrap_cnt <= '0;
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + W'(1);
          if (tick) begin
            if (wrap_now) begin
              count      <= '0;
              wrap_pulse <= 1'b1;
              if (wrap_cnt != '1) wrap_cnt <= wrap_cnt + W'(1);
              if (oneshot) state <= DONE;
            end else begin
              count <= count + W'(1);
            end
          end
          // A wrap in the same clock as RUN dropping is still counted, but IDLE wins.
          if (!run) begin
            state <= IDLE;
            presc <= '0;
            count <= '0;
          end
        end
        DONE: begin
          presc <= '0;
          count <= '0;
          if (!run) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    status_regs            = '0;
    status_regs[0   +: W]  = count;
    status_regs[W   +: W]  = wrap_cnt;
    status_regs[2*W +: W]  = W'({state == DONE, state == RUN, pwm_out});
    status_regs[3*W +: W]  = W'(8'hA5);
  end
endmodule

// File: tb/tb_pwm_timer.sv
// Bench for pwm_timer: a per-cycle behavioural model checked every clock, plus directed
// scenarios with hand-computed expectations (free run, prescale, one-shot, saturation, shadow).
module tb_pwm_timer;
  logic        clk = 1'b0;
  logic        rstb, ena;
  logic [7:0]  ctrl_b, pre_b, per_b, duty_b;
  logic [63:0] config_regs, status_regs;
  logic        pwm_out, wrap_pulse;
  int          errors = 0, checks = 0;
  int          pw_hi = 0, wp_hi = 0;

  assign config_regs = {32'h0, duty_b, per_b, pre_b, ctrl_b};

  pwm_timer dut (
    .clk(clk), .rstb(rstb), .ena(ena), .config_regs(config_regs),
    .status_regs(status_regs), .pwm_out(pwm_out), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  // Model: timer phase 0=idle 1=running 2=done, tick/prescale/period arithmetic on ints.
  int m_st = 0, m_pre = 0, m_cnt = 0, m_wraps = 0, m_psh = 0, m_dsh = 0, m_pwm = 0, m_wp = 0;

  always @(posedge clk or negedge rstb) begin
    int per_eff, duty_eff;
    bit go, one, inv, ticked;
    if (!rstb) begin
      m_st = 0; m_pre = 0; m_cnt = 0; m_wraps = 0; m_psh = 0; m_dsh = 0; m_pwm = 0; m_wp = 0;
    end else if (ena) begin
      go  = ctrl_b[0];
      one = ctrl_b[1];
      inv = ctrl_b[2];
`ifdef PWM_TIMER_SHADOW_EN
      per_eff  = m_psh;
      duty_eff = m_dsh;
`else
      per_eff  = int'(per_b);
      duty_eff = int'(duty_b);
`endif
      m_pwm = (inv ^ (m_st == 1 && m_cnt < duty_eff)) ? 1 : 0;
      m_wp  = 0;
      if (m_st == 0) begin
        m_pre = 0; m_cnt = 0;
        if (go) begin
          m_st = 1; m_wraps = 0; m_psh = int'(per_b); m_dsh = int'(duty_b);
        end
      end else if (m_st == 1) begin
        ticked = (m_pre == int'(pre_b));
        m_pre  = ticked ? 0 : (m_pre + 1) % 256;
        if (ticked) begin
          if (m_cnt == per_eff) begin
            m_cnt = 0; m_wp = 1;
            m_wraps = (m_wraps < 255) ? m_wraps + 1 : 255;
            m_psh = int'(per_b); m_dsh = int'(duty_b);
            if (one) m_st = 2;
          end else begin
            m_cnt = (m_cnt + 1) % 256;
          end
        end
        if (!go) begin
          m_st = 0; m_pre = 0; m_cnt = 0;
        end
      end else begin
        m_pre = 0; m_cnt = 0;
        if (!go) m_st = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] exp_s;
    if (rstb) begin
      exp_s = {32'h0, 8'hA5, 5'b0, m_st == 2, m_st == 1, m_pwm[0], 8'(m_wraps), 8'(m_cnt)};
      checks++;
      if (status_regs !== exp_s || pwm_out !== m_pwm[0] || wrap_pulse !== m_wp[0]) begin
        errors++;
        $display("FAIL model t=%0t status=%h pwm=%b wrap=%b required status=%h pwm=%0d wrap=%0d",
                 $time, status_regs, pwm_out, wrap_pulse, exp_s, m_pwm, m_wp);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      pw_hi += int'(pwm_out);
      wp_hi += int'(wrap_pulse);
    end
  endtask

  task automatic go_idle();
    ctrl_b = 8'h00;
    cyc(2);
  endtask

  initial begin
    ena = 1'b1; ctrl_b = 8'h00; pre_b = 8'h00; per_b = 8'h00; duty_b = 8'h00;
    rstb = 1'b1;
    #2 rstb = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_status", status_regs, 64'h00000000_A5000000);
    chk("reset_pwm", pwm_out, 0);
    chk("reset_wrap", wrap_pulse, 0);
    rstb = 1'b1;
    cyc(1);

    // Free run: period 4 clks, high for 2.
    pre_b = 8'd0; per_b = 8'd3; duty_b = 8'd2; ctrl_b = 8'h01;
    cyc(1);
    pw_hi = 0; wp_hi = 0;
    cyc(40);
    chk("free_pwm_high", pw_hi, 20);
    chk("free_wraps", wp_hi, 10);
    chk("free_wrap_cnt", status_regs[15:8], 10);
    chk("free_byte2", status_regs[23:16], 8'h02);

    // Freeze while a wrap pulse is pending.
    cyc(4);
    chk("pre_freeze_wrap", wrap_pulse, 1);
    ena = 1'b0;
    cyc(3);
    chk("freeze_wrap_held", wrap_pulse, 1);
    chk("freeze_wrap_cnt", status_regs[15:8], 11);
    ena = 1'b1;
    cyc(1);
    chk("unfreeze_wrap", wrap_pulse, 0);
    chk("unfreeze_count", status_regs[7:0], 1);

    // RUN dropped in the same clock as a wrap.
    cyc(2);
    ctrl_b = 8'h00;
    cyc(1);
    chk("stop_at_wrap_pulse", wrap_pulse, 1);
    chk("stop_at_wrap_cnt", status_regs[15:8], 12);
    chk("stop_at_wrap_byte2", status_regs[23:16], 8'h00);
    cyc(2);
    chk("idle_holds_wrap_cnt", status_regs[15:8], 12);

    // Prescale 4, period 1: first tick 5 clks in, wrap every 10.
    pre_b = 8'd4; per_b = 8'd1; duty_b = 8'd0; ctrl_b = 8'h01;
    cyc(1);
    chk("entry_clears_wrap_cnt", status_regs[15:8], 0);
    cyc(5);
    chk("presc_first_tick", status_regs[7:0], 1);
    cyc(4);
    chk("presc_no_wrap_yet", wrap_pulse, 0);
    cyc(1);
    chk("presc_first_wrap", wrap_pulse, 1);
    wp_hi = 0;
    cyc(30);
    chk("presc_wraps", wp_hi, 3);
    go_idle();

    // One-shot.
    pre_b = 8'd0; per_b = 8'd5; duty_b = 8'd2; ctrl_b = 8'h03;
    wp_hi = 0;
    cyc(20);
    chk("oneshot_wraps", wp_hi, 1);
    chk("oneshot_byte2", status_regs[23:16], 8'h04);
    chk("oneshot_count", status_regs[7:0], 0);
    ctrl_b = 8'h00;
    cyc(1);
    chk("oneshot_cleared", status_regs[23:16], 8'h00);
    cyc(1);

    // Wrap every clock, inverted, zero duty: counter saturates, output stuck high.
    pre_b = 8'd0; per_b = 8'd0; duty_b = 8'd0; ctrl_b = 8'h05;
    cyc(1);
    pw_hi = 0;
    cyc(300);
    chk("sat_wrap_cnt", status_regs[15:8], 255);
    chk("sat_pwm_high", pw_hi, 300);

    // Reset mid-run takes effect without a clock.
    rstb = 1'b0;
    #1;
    chk("midrun_reset_status", status_regs, 64'h00000000_A5000000);
    chk("midrun_reset_wrap", wrap_pulse, 0);
    @(negedge clk);
    rstb = 1'b1;
    go_idle();

    // PERIOD 7 -> 2 while count is 3.
    pre_b = 8'd0; per_b = 8'd7; duty_b = 8'd0; ctrl_b = 8'h01;
    cyc(4);
    chk("shadow_count3", status_regs[7:0], 3);
    per_b = 8'd2;
    wp_hi = 0;
    cyc(5);
`ifdef PWM_TIMER_SHADOW_EN
    chk("shadow_wrap_at_7", wrap_pulse, 1);
`else
    chk("live_no_wrap_at_8", wrap_pulse, 0);
`endif
    cyc(251);
`ifdef PWM_TIMER_SHADOW_EN
    chk("shadow_total_wraps", wp_hi, 84);
`else
    chk("live_total_wraps", wp_hi, 1);
`endif
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
